// File: rtl/axi_ram_arbiter.sv
// Two-master to one-slave arbiter for a DDR RAM port with merged read/write address channel.
// Serves one whole transaction at a time and picks between simultaneous requests round-robin.
module axi_ram_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    // master 0
    input  logic                  m0_arw_valid,
    output logic                  m0_arw_ready,
    input  logic [ADDR_W-1:0]     m0_arw_addr,
    input  logic [7:0]            m0_arw_len,
    input  logic                  m0_arw_write,
    input  logic                  m0_w_valid,
    output logic                  m0_w_ready,
    input  logic [DATA_W-1:0]     m0_w_data,
    input  logic [DATA_W/8-1:0]   m0_w_strb,
    input  logic                  m0_w_last,
    output logic                  m0_b_valid,
    input  logic                  m0_b_ready,
    output logic                  m0_r_valid,
    input  logic                  m0_r_ready,
    output logic [DATA_W-1:0]     m0_r_data,
    output logic                  m0_r_last,

    // master 1
    input  logic                  m1_arw_valid,
    output logic                  m1_arw_ready,
    input  logic [ADDR_W-1:0]     m1_arw_addr,
    input  logic [7:0]            m1_arw_len,
    input  logic                  m1_arw_write,
    input  logic                  m1_w_valid,
    output logic                  m1_w_ready,
    input  logic [DATA_W-1:0]     m1_w_data,
    input  logic [DATA_W/8-1:0]   m1_w_strb,
    input  logic                  m1_w_last,
    output logic                  m1_b_valid,
    input  logic                  m1_b_ready,
    output logic                  m1_r_valid,
    input  logic                  m1_r_ready,
    output logic [DATA_W-1:0]     m1_r_data,
    output logic                  m1_r_last,

    // slave (DDR controller)
    output logic                  s_arw_valid,
    input  logic                  s_arw_ready,
    output logic [ADDR_W-1:0]     s_arw_addr,
    output logic [7:0]            s_arw_len,
    output logic                  s_arw_write,
    output logic                  s_w_valid,
    input  logic                  s_w_ready,
    output logic [DATA_W-1:0]     s_w_data,
    output logic [DATA_W/8-1:0]   s_w_strb,
    output logic                  s_w_last,
    input  logic                  s_b_valid,
    output logic                  s_b_ready,
    input  logic                  s_r_valid,
    output logic                  s_r_ready,
    input  logic [DATA_W-1:0]     s_r_data,
    input  logic                  s_r_last
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WRESP = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   g, g_nxt;
    logic   last_grant, last_grant_nxt;
    logic   win;

    logic                mg_arw_valid;
    logic [ADDR_W-1:0]   mg_arw_addr;
    logic [7:0]          mg_arw_len;
    logic                mg_arw_write;
    logic                mg_w_valid;
    logic [DATA_W-1:0]   mg_w_data;
    logic [STRB_W-1:0]   mg_w_strb;
    logic                mg_w_last;
    logic                mg_b_ready;
    logic                mg_r_ready;

    // Granted-master view of the request-side signals
    always_comb begin
        mg_arw_valid = g ? m1_arw_valid : m0_arw_valid;
        mg_arw_addr  = g ? m1_arw_addr  : m0_arw_addr;
        mg_arw_len   = g ? m1_arw_len   : m0_arw_len;
        mg_arw_write = g ? m1_arw_write : m0_arw_write;
        mg_w_valid   = g ? m1_w_valid   : m0_w_valid;
        mg_w_data    = g ? m1_w_data    : m0_w_data;
        mg_w_strb    = g ? m1_w_strb    : m0_w_strb;
        mg_w_last    = g ? m1_w_last    : m0_w_last;
        mg_b_ready   = g ? m1_b_ready   : m0_b_ready;
        mg_r_ready   = g ? m1_r_ready   : m0_r_ready;
    end

    // Round-robin pick: on a tie the master that did not go last wins
    always_comb begin
        if (m0_arw_valid && m1_arw_valid) begin
            win = ~last_grant;
        end else begin
            win = m1_arw_valid;
        end
    end

    // Payloads are passed straight through; only the valid/ready pairs are gated by state
    assign s_arw_addr  = mg_arw_addr;
    assign s_arw_len   = mg_arw_len;
    assign s_arw_write = mg_arw_write;
    assign s_w_data    = mg_w_data;
    assign s_w_strb    = mg_w_strb;
    assign s_w_last    = mg_w_last;
    assign m0_r_data   = s_r_data;
    assign m1_r_data   = s_r_data;
    assign m0_r_last   = s_r_last;
    assign m1_r_last   = s_r_last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            g          <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            g          <= g_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt      = state;
        g_nxt          = g;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (m0_arw_valid || m1_arw_valid) begin
                    state_nxt = ADDR;
                    g_nxt     = win;
                end
            end
            ADDR: begin
                if (mg_arw_valid && s_arw_ready) begin
                    state_nxt = mg_arw_write ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (mg_w_valid && s_w_ready && mg_w_last) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                if (s_b_valid && mg_b_ready) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = g;
                end
            end
            RDATA: begin
                if (s_r_valid && mg_r_ready && s_r_last) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = g;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake routing; the non-granted master never sees a ready or valid
    always_comb begin
        m0_arw_ready = 1'b0;
        m1_arw_ready = 1'b0;
        m0_w_ready   = 1'b0;
        m1_w_ready   = 1'b0;
        m0_b_valid   = 1'b0;
        m1_b_valid   = 1'b0;
        m0_r_valid   = 1'b0;
        m1_r_valid   = 1'b0;
        s_arw_valid  = 1'b0;
        s_w_valid    = 1'b0;
        s_b_ready    = 1'b0;
        s_r_ready    = 1'b0;
        case (state)
            ADDR: begin
                s_arw_valid  = mg_arw_valid;
                m0_arw_ready = ~g & s_arw_ready;
                m1_arw_ready =  g & s_arw_ready;
            end
            WDATA: begin
                s_w_valid  = mg_w_valid;
                m0_w_ready = ~g & s_w_ready;
                m1_w_ready =  g & s_w_ready;
            end
            WRESP: begin
                s_b_ready  = mg_b_ready;
                m0_b_valid = ~g & s_b_valid;
                m1_b_valid =  g & s_b_valid;
            end
            RDATA: begin
                s_r_ready  = mg_r_ready;
                m0_r_valid = ~g & s_r_valid;
                m1_r_valid =  g & s_r_valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// Directed bench for axi_ram_arbiter: a per-cycle vector table for the handshake routing,
// plus hand sequences for write payload order, read backpressure and mid-burst reset.
module tb_axi_ram_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] M0_ADDR = 28'h100;
    localparam logic [ADDR_W-1:0] M1_ADDR = 28'h40;
    localparam logic [7:0]        M0_LEN  = 8'd3;
    localparam logic [7:0]        M1_LEN  = 8'd1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]          m_arw_valid, m_arw_write, m_w_valid, m_w_last, m_b_ready, m_r_ready;
    logic [ADDR_W-1:0]   m_arw_addr [2];
    logic [7:0]          m_arw_len  [2];
    logic [DATA_W-1:0]   m_w_data   [2];
    logic [DATA_W/8-1:0] m_w_strb   [2];

    logic s_arw_ready, s_w_ready, s_b_valid, s_r_valid, s_r_last;
    logic [DATA_W-1:0] s_r_data;

    logic m0_arw_ready, m0_w_ready, m0_b_valid, m0_r_valid, m0_r_last;
    logic m1_arw_ready, m1_w_ready, m1_b_valid, m1_r_valid, m1_r_last;
    logic [DATA_W-1:0] m0_r_data, m1_r_data;
    logic s_arw_valid, s_arw_write, s_w_valid, s_w_last, s_b_ready, s_r_ready;
    logic [ADDR_W-1:0] s_arw_addr;
    logic [7:0]        s_arw_len;
    logic [DATA_W-1:0] s_w_data;
    logic [DATA_W/8-1:0] s_w_strb;

    axi_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .m0_arw_valid(m_arw_valid[0]), .m0_arw_ready(m0_arw_ready), .m0_arw_addr(m_arw_addr[0]),
        .m0_arw_len(m_arw_len[0]), .m0_arw_write(m_arw_write[0]),
        .m0_w_valid(m_w_valid[0]), .m0_w_ready(m0_w_ready), .m0_w_data(m_w_data[0]),
        .m0_w_strb(m_w_strb[0]), .m0_w_last(m_w_last[0]),
        .m0_b_valid(m0_b_valid), .m0_b_ready(m_b_ready[0]),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m_r_ready[0]), .m0_r_data(m0_r_data), .m0_r_last(m0_r_last),
        .m1_arw_valid(m_arw_valid[1]), .m1_arw_ready(m1_arw_ready), .m1_arw_addr(m_arw_addr[1]),
        .m1_arw_len(m_arw_len[1]), .m1_arw_write(m_arw_write[1]),
        .m1_w_valid(m_w_valid[1]), .m1_w_ready(m1_w_ready), .m1_w_data(m_w_data[1]),
        .m1_w_strb(m_w_strb[1]), .m1_w_last(m_w_last[1]),
        .m1_b_valid(m1_b_valid), .m1_b_ready(m_b_ready[1]),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m_r_ready[1]), .m1_r_data(m1_r_data), .m1_r_last(m1_r_last),
        .s_arw_valid(s_arw_valid), .s_arw_ready(s_arw_ready), .s_arw_addr(s_arw_addr),
        .s_arw_len(s_arw_len), .s_arw_write(s_arw_write),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_last(s_r_last)
    );

    // {m1/m0 arw_ready, m1/m0 w_ready, m1/m0 b_valid, m1/m0 r_valid, s_arw_valid, s_w_valid, s_b_ready, s_r_ready}
    logic [11:0] hs;
    assign hs = {m1_arw_ready, m0_arw_ready, m1_w_ready, m0_w_ready, m1_b_valid, m0_b_valid,
                 m1_r_valid, m0_r_valid, s_arw_valid, s_w_valid, s_b_ready, s_r_ready};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] av, aw;
        logic       sar;
        logic [1:0] wv;
        logic       wl, swr, sbv;
        logic [1:0] br;
        logic       srv, srl;
        logic [1:0] rr;
        logic       sel;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic [1:0] av, input logic [1:0] aw,
                               input logic sar, input logic [1:0] wv, input logic wl,
                               input logic swr, input logic sbv, input logic [1:0] br,
                               input logic srv, input logic srl, input logic [1:0] rr,
                               input logic sel, input logic [11:0] exp);
        vec_t r;
        r.rst = rst; r.av = av; r.aw = aw; r.sar = sar; r.wv = wv; r.wl = wl;
        r.swr = swr; r.sbv = sbv; r.br = br; r.srv = srv; r.srl = srl; r.rr = rr;
        r.sel = sel; r.exp = exp;
        return r;
    endfunction

    task automatic clear_inputs();
        m_arw_valid = '0; m_arw_write = '0; m_w_valid = '0; m_w_last = '0;
        m_b_ready = '0; m_r_ready = '0;
        s_arw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0;
        s_r_valid = 1'b0; s_r_last = 1'b0; s_r_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Drive one master's address request until the slave side handshakes, bounded
    task automatic do_addr(input int m, input logic wr);
        bit done = 1'b0;
        m_arw_valid[m] = 1'b1;
        m_arw_write[m] = wr;
        s_arw_ready = 1'b1;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (s_arw_valid && s_arw_ready) begin
                done = 1'b1;
                check($sformatf("m%0d_arw_addr", m), 64'(s_arw_addr), 64'(m ? M1_ADDR : M0_ADDR));
                check($sformatf("m%0d_arw_len", m), 64'(s_arw_len), 64'(m ? M1_LEN : M0_LEN));
                check($sformatf("m%0d_arw_write", m), 64'(s_arw_write), 64'(wr));
                check($sformatf("m%0d_arw_ready_route", m), 64'({m1_arw_ready, m0_arw_ready}),
                      64'(m ? 2'b10 : 2'b01));
            end
            tick();
        end
        if (!done) check($sformatf("m%0d_arw_timeout", m), 64'(0), 64'(1));
        m_arw_valid[m] = 1'b0;
        s_arw_ready = 1'b0;
    endtask

    vec_t tbl[$];
    logic [DATA_W-1:0] rd_beats [4];
    logic [DATA_W-1:0] got_d[$];
    logic              got_l[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_arw_addr[0] = M0_ADDR; m_arw_len[0] = M0_LEN;
        m_arw_addr[1] = M1_ADDR; m_arw_len[1] = M1_LEN;
        m_w_data[0] = 32'hA5A5_0000; m_w_data[1] = 32'h5A5A_0001;
        m_w_strb[0] = 4'hF; m_w_strb[1] = 4'hF;
        rd_beats[0] = 32'h1111_1111; rd_beats[1] = 32'h2222_2222;
        rd_beats[2] = 32'h3333_3333; rd_beats[3] = 32'h4444_4444;
        clear_inputs();
        reset = 1'b1;
        repeat (2) tick();

        //        rst  av     aw     sar  wv     wl  swr sbv br     srv srl rr     sel exp
        tbl.push_back(v(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_1000));
        tbl.push_back(v(0, 2'b01, 2'b00, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b01_00_00_00_1000));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 2'b11, 0, 12'b00_00_00_01_0001));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 2'b11, 0, 12'b00_00_00_01_0001));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 2'b11, 0, 12'b00_00_00_01_0001));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 2'b11, 0, 12'b00_00_00_01_0001));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));
        // simultaneous requests from reset: m0 first, then m1, then m0 again
        tbl.push_back(v(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));
        tbl.push_back(v(0, 2'b11, 2'b10, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));
        tbl.push_back(v(0, 2'b11, 2'b10, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b01_00_00_00_1000));
        tbl.push_back(v(0, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 2'b01, 0, 12'b00_00_00_01_0001));
        tbl.push_back(v(0, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));
        tbl.push_back(v(0, 2'b10, 2'b10, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 12'b10_00_00_00_1000));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b10, 0, 1, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_10_00_00_0100));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b10, 1, 1, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_10_00_00_0100));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_10_00_0000));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 2'b10, 0, 0, 2'b00, 0, 12'b00_00_10_00_0010));
        tbl.push_back(v(0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b01_00_00_00_1000));
        // m1 waits through m0's write until the b handshake
        tbl.push_back(v(0, 2'b10, 2'b11, 0, 2'b01, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0100));
        tbl.push_back(v(0, 2'b10, 2'b11, 0, 2'b01, 1, 1, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_01_00_00_0100));
        tbl.push_back(v(0, 2'b10, 2'b11, 0, 2'b00, 0, 0, 0, 2'b01, 0, 0, 2'b00, 0, 12'b00_00_00_00_0010));
        tbl.push_back(v(0, 2'b10, 2'b11, 0, 2'b00, 0, 0, 1, 2'b11, 0, 0, 2'b00, 0, 12'b00_00_01_00_0010));
        tbl.push_back(v(0, 2'b10, 2'b11, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));
        tbl.push_back(v(0, 2'b10, 2'b11, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 12'b00_00_00_00_1000));
        tbl.push_back(v(0, 2'b10, 2'b11, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 12'b10_00_00_00_1000));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b10, 1, 1, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_10_00_00_0100));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 2'b10, 0, 0, 2'b00, 0, 12'b00_00_10_00_0010));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 12'b00_00_00_00_0000));

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            m_arw_valid = tbl[i].av; m_arw_write = tbl[i].aw; s_arw_ready = tbl[i].sar;
            m_w_valid = tbl[i].wv; m_w_last = {2{tbl[i].wl}}; s_w_ready = tbl[i].swr;
            s_b_valid = tbl[i].sbv; m_b_ready = tbl[i].br;
            s_r_valid = tbl[i].srv; s_r_last = tbl[i].srl; m_r_ready = tbl[i].rr;
            @(negedge clk);
            check($sformatf("vec%0d_hs", i), 64'(hs), 64'(tbl[i].exp));
            if (tbl[i].exp[3]) begin
                check($sformatf("vec%0d_arw_addr", i), 64'(s_arw_addr),
                      64'(tbl[i].sel ? M1_ADDR : M0_ADDR));
                check($sformatf("vec%0d_arw_write", i), 64'(s_arw_write), 64'(tbl[i].aw[tbl[i].sel]));
            end
            tick();
        end

        // m1 two-beat write: payload order, strobes and w_last placement
        do_reset();
        m_w_strb[1] = 4'hF;
        do_addr(1, 1'b1);
        m_w_valid[1] = 1'b1; m_w_data[1] = 32'hDEAD_BEEF; m_w_last[1] = 1'b0; s_w_ready = 1'b0;
        @(negedge clk);
        check("wr_stall_hs", 64'(hs), 64'(12'b00_00_00_00_0100));
        tick();
        s_w_ready = 1'b1;
        @(negedge clk);
        check("wr_beat0_data", 64'(s_w_data), 64'(32'hDEAD_BEEF));
        check("wr_beat0_last", 64'(s_w_last), 64'(0));
        check("wr_beat0_ready", 64'({m1_w_ready, m0_w_ready}), 64'(2'b10));
        tick();
        m_w_data[1] = 32'h1234_5678; m_w_last[1] = 1'b1;
        @(negedge clk);
        check("wr_beat1_data", 64'(s_w_data), 64'(32'h1234_5678));
        check("wr_beat1_last", 64'(s_w_last), 64'(1));
        check("wr_beat1_strb", 64'(s_w_strb), 64'(4'hF));
        tick();
        m_w_valid = '0; s_w_ready = 1'b0; s_b_valid = 1'b1; m_b_ready = 2'b11;
        @(negedge clk);
        check("wr_resp_hs", 64'(hs), 64'(12'b00_00_10_00_0010));
        tick();
        s_b_valid = 1'b0;
        @(negedge clk);
        check("wr_done_idle", 64'(hs), 64'(0));

        // m0 four-beat read with toggling s_r_valid and m0_r_ready low for 3 cycles
        do_reset();
        do_addr(0, 1'b0);
        begin
            int k = 0;
            int leak = 0;
            bit adv;
            got_d.delete(); got_l.delete();
            for (int c = 0; c < 40 && got_d.size() < 4; c++) begin
                s_r_valid = (k < 4) && ((c % 3) != 1);
                s_r_data  = rd_beats[(k < 4) ? k : 3];
                s_r_last  = (k == 3);
                m_r_ready = (c >= 2 && c < 5) ? 2'b10 : 2'b11;
                @(negedge clk);
                if (m1_r_valid) leak++;
                adv = s_r_valid && s_r_ready;
                if (m0_r_valid && m_r_ready[0]) begin
                    got_d.push_back(m0_r_data);
                    got_l.push_back(m0_r_last);
                end
                tick();
                if (adv) k++;
            end
            check("rd_beat_count", 64'(got_d.size()), 64'(4));
            foreach (got_d[i]) begin
                check($sformatf("rd_beat%0d_data", i), 64'(got_d[i]), 64'(rd_beats[i]));
                check($sformatf("rd_beat%0d_last", i), 64'(got_l[i]), 64'(i == 3));
            end
            check("rd_m1_r_valid_leak", 64'(leak), 64'(0));
            s_r_valid = 1'b1; s_r_last = 1'b0;
            @(negedge clk);
            check("rd_done_idle", 64'(hs), 64'(0));
            tick();
        end

        // reset after two of four read beats, then a normal m1 read
        do_reset();
        do_addr(0, 1'b0);
        s_r_valid = 1'b1; s_r_last = 1'b0; m_r_ready = 2'b11;
        for (int b = 0; b < 2; b++) begin
            s_r_data = rd_beats[b];
            @(negedge clk);
            check($sformatf("rst_rd_beat%0d_valid", b), 64'({m1_r_valid, m0_r_valid}), 64'(2'b01));
            tick();
        end
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("rst_abort_hs", 64'(hs), 64'(0));
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("rst_after_idle_hs", 64'(hs), 64'(0));
        s_r_valid = 1'b0;
        tick();
        do_addr(1, 1'b0);
        s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 32'hCAFE_0001; m_r_ready = 2'b11;
        @(negedge clk);
        check("rst_m1_r_hs", 64'(hs), 64'(12'b00_00_00_10_0001));
        check("rst_m1_r_data", 64'(m1_r_data), 64'(32'hCAFE_0001));
        tick();
        s_r_valid = 1'b0; s_r_last = 1'b0;
        @(negedge clk);
        check("rst_m1_done_idle", 64'(hs), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
